pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline hazard and stall controller that drives the enable and flush inputs of the IF/ID, ID/EX and EX/MEM registers and the PC register. It consumes the EX-stage outputs of the ID/EX register (rd address, write-back enable, memory-read code) together with the ID-stage source addresses. It resolves four cases:
- load-use hazards, by stalling the front end and inserting a bubble;
- taken branches, by flushing the younger stages;
- data-memory wait states, by freezing the whole pipeline;
- memory timeouts, via an error state.
It also keeps saturating performance counters.

Parameters:
CNT_W, 32, width of the stall and flush performance counters
MAX_WAIT, 16, consecutive MEM_WAIT cycles before entering ERR (range 2..255)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
id_rs1_addr  in  5  rs1 address of the instruction in ID
id_rs2_addr  in  5  rs2 address of the instruction in ID
id_rs1_used  in  1  the ID instruction reads rs1
id_rs2_used  in  1  the ID instruction reads rs2
ex_rd_addr  in  5  rd address from the ID/EX register
ex_wb_en  in  1  write-back enable from the ID/EX register
ex_mem_read  in  3  memory-read code from the ID/EX register; nonzero means load
ex_branch_taken  in  1  the EX instruction redirects the PC this cycle
mem_req  in  1  the MEM stage is issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC register update enable
if_id_en  out  1  IF/ID enable
if_id_flush  out  1  IF/ID loads a bubble (all zero) on this edge
id_ex_en  out  1  ID/EX enable
id_ex_flush  out  1  ID/EX loads a bubble on this edge
ex_mem_en  out  1  EX/MEM enable
mem_timeout  out  1  sticky error flag
stall_cycles  out  CNT_W  count of cycles with pc_en=0, excluding ERR
flush_cycles  out  CNT_W  count of cycles with id_ex_flush=1

Behaviour:
- Clock and reset:
  - Single clock domain; rst_n is asynchronous and active-low.
  - While rst_n=0: state=RUN, wait_cnt=0, counters=0, mem_timeout=0.
  - While rst_n=0, all enables and flushes are forced to 0.
  - Reset asserted mid-stall or mid-wait aborts immediately. The first cycle after release is RUN evaluation.
- Output timing:
  - Outputs are combinational from the registered state plus the current inputs (Mealy). Hazard response has zero-cycle latency.
  - Flush takes effect only when the matching enable is 1. The controller always asserts the enable together with its flush.
- Load-use detect (lu), all conditions required:
  - ex_mem_read!=0, ex_wb_en=1 and ex_rd_addr!=0;
  - and either (id_rs1_used and id_rs1_addr==ex_rd_addr) or (id_rs2_used and id_rs2_addr==ex_rd_addr).
- Memory wait: mw = mem_req and not mem_ready.
- State RUN, first matching rule wins:
  1. mw: pc_en=if_id_en=id_ex_en=ex_mem_en=0, no flush. Next state MEM_WAIT, wait_cnt<=1.
  2. ex_branch_taken: all enables=1, if_id_flush=1, id_ex_flush=1. Branch wins over lu because the ID instruction is discarded.
  3. lu: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1. The load advances; next cycle lu clears naturally, so each load-use costs exactly 1 bubble.
  4. Otherwise all enables=1 and flushes=0.
- State MEM_WAIT:
  - If mem_ready=0:
    - All enables are 0.
    - If wait_cnt==MAX_WAIT-1, next state ERR and mem_timeout<=1.
    - Otherwise wait_cnt increments.
  - If mem_ready=1:
    - Outputs are evaluated by RUN rules 2-4, with mw treated as 0.
    - Next state RUN, wait_cnt<=0.
  - A branch frozen in EX during the wait is acted on in the release cycle.
- State ERR:
  - All enables and flushes are 0.
  - mem_timeout=1 and counters are frozen.
  - Exit only by reset.
- Counters:
  - Increment by 1 on qualifying cycles.
  - Saturate at all-ones with no wrap.
- State encoding: 2 bits (RUN=0, MEM_WAIT=1, ERR=2). The unused code 3 is treated as ERR.

Test Plan:
- Load-use: load with ex_rd_addr=5, id_rs1_addr=5, id_rs1_used=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1. Next cycle with ex_mem_read=0: all en=1. stall_cycles=1, flush_cycles=1.
- No false hazard:
  - ex_rd_addr=0 with a matching rs -> no stall.
  - ex_mem_read=0 (ALU op) with a match -> no stall.
  - Match on rs2 with id_rs2_used=0 -> no stall.
- Branch vs load-use in the same cycle: ex_branch_taken=1 and lu=1 -> pc_en=1, if_id_flush=1, id_ex_flush=1; stall_cycles unchanged.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high -> 3 cycles with all en=0, then one cycle with all en=1. stall_cycles=3, mem_timeout=0.
- Timeout: MAX_WAIT=4, mem_ready held low -> after 4 frozen cycles mem_timeout=1, and it stays 1 when mem_ready later rises. Asserting rst_n=0 clears mem_timeout and both counters to 0.
- Saturation: CNT_W=4 with a continuous load-use pattern over 20 hazards -> stall_cycles holds at 15 and does not wrap.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes,
// data-memory wait freezing with timeout, and saturating stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_wb_en,
    input  logic [2:0]       ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2,
        ST_BAD  = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t     state_reg, state_next;
    logic [7:0] wait_cnt_reg, wait_cnt_next;
    logic       timeout_reg, timeout_next;

    logic lu, mw;
    logic pc_en_c, if_id_en_c, if_id_flush_c, id_ex_en_c, id_ex_flush_c, ex_mem_en_c;
    logic rule_pc_en, rule_if_id_en, rule_flush_br, rule_id_ex_flush;

    assign lu = (ex_mem_read != 3'd0) && ex_wb_en && (ex_rd_addr != 5'd0) &&
                ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                 (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
    assign mw = mem_req && !mem_ready;

    // Branch / load-use / normal priority, shared by RUN and the wait-release cycle
    always_comb begin
        rule_pc_en       = 1'b1;
        rule_if_id_en    = 1'b1;
        rule_flush_br    = 1'b0;
        rule_id_ex_flush = 1'b0;
        if (ex_branch_taken) begin
            rule_flush_br    = 1'b1;
            rule_id_ex_flush = 1'b1;
        end else if (lu) begin
            rule_pc_en       = 1'b0;
            rule_if_id_en    = 1'b0;
            rule_id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        pc_en_c       = 1'b0;
        if_id_en_c    = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_en_c    = 1'b0;
        id_ex_flush_c = 1'b0;
        ex_mem_en_c   = 1'b0;
        case (state_reg)
            ST_RUN, ST_WAIT: begin
                if ((state_reg == ST_RUN && mw) || (state_reg == ST_WAIT && !mem_ready)) begin
                    if (state_reg == ST_RUN) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = 8'd1;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        state_next   = ST_ERR;
                        timeout_next = 1'b1;
                    end else begin
                        wait_cnt_next = wait_cnt_reg + 8'd1;
                    end
                end else begin
                    pc_en_c       = rule_pc_en;
                    if_id_en_c    = rule_if_id_en;
                    if_id_flush_c = rule_flush_br;
                    id_ex_en_c    = 1'b1;
                    id_ex_flush_c = rule_id_ex_flush;
                    ex_mem_en_c   = 1'b1;
                    state_next    = ST_RUN;
                    wait_cnt_next = 8'd0;
                end
            end
            default: begin
                state_next = state_reg;
            end
        endcase
    end

    // Everything is held off while reset is asserted
    assign pc_en       = rst_n & pc_en_c;
    assign if_id_en    = rst_n & if_id_en_c;
    assign if_id_flush = rst_n & if_id_flush_c;
    assign id_ex_en    = rst_n & id_ex_en_c;
    assign id_ex_flush = rst_n & id_ex_flush_c;
    assign ex_mem_en   = rst_n & ex_mem_en_c;
    assign mem_timeout = timeout_reg | state_reg[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= 8'd0;
            timeout_reg  <= 1'b0;
            stall_cycles <= '0;
            flush_cycles <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
            if (!state_reg[1] && !pc_en_c && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (id_ex_flush_c && (flush_cycles != '1))
                flush_cycles <= flush_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a table of single-cycle RUN vectors plus
// hand-written sequences for memory wait, timeout, reset and saturation.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W    = 4;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic id_rs1_used, id_rs2_used, ex_wb_en, ex_branch_taken, mem_req, mem_ready;
    logic [2:0] ex_mem_read;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_timeout;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    // exp = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] rd;
        logic       wb;
        logic [2:0] mr;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    localparam logic [5:0] ALL_RUN = 6'b110101;
    localparam logic [5:0] LU_STL  = 6'b000111;
    localparam logic [5:0] BR_FL   = 6'b111111;
    localparam logic [5:0] FROZEN  = 6'b000000;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                         input logic u2, input logic [4:0] rd, input logic wb,
                         input logic [2:0] mr, input logic br, input logic req,
                         input logic rdy);
        id_rs1_addr = rs1; id_rs2_addr = rs2; id_rs1_used = u1; id_rs2_used = u2;
        ex_rd_addr = rd; ex_wb_en = wb; ex_mem_read = mr; ex_branch_taken = br;
        mem_req = req; mem_ready = rdy;
    endtask

    task automatic idle();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic check_outs(input string name, input logic [5:0] exp);
        logic [5:0] act;
        act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"lu_rs1",      5'd5, 5'd0, 1, 0, 5'd5, 1, 3'b010, 0, LU_STL};
        vecs[1] = '{"alu_after",   5'd5, 5'd0, 1, 0, 5'd5, 1, 3'b000, 0, ALL_RUN};
        vecs[2] = '{"rd_zero",     5'd0, 5'd0, 1, 0, 5'd0, 1, 3'b010, 0, ALL_RUN};
        vecs[3] = '{"rs2_unused",  5'd0, 5'd7, 1, 0, 5'd7, 1, 3'b100, 0, ALL_RUN};
        vecs[4] = '{"lu_rs2",      5'd0, 5'd7, 0, 1, 5'd7, 1, 3'b100, 0, LU_STL};
        vecs[5] = '{"wb_off",      5'd5, 5'd0, 1, 0, 5'd5, 0, 3'b010, 0, ALL_RUN};
        vecs[6] = '{"br_over_lu",  5'd5, 5'd0, 1, 0, 5'd5, 1, 3'b010, 1, BR_FL};
        vecs[7] = '{"br_only",     5'd1, 5'd2, 1, 1, 5'd9, 1, 3'b000, 1, BR_FL};
        vecs[8] = '{"rs1_unused",  5'd5, 5'd0, 0, 0, 5'd5, 1, 3'b010, 0, ALL_RUN};

        // Reset holds all enables low and clears state
        rst_n = 1'b0;
        idle();
        #2;
        check_outs("in_reset", FROZEN);
        check_val("rst_timeout", int'(mem_timeout), 0);
        check_val("rst_stall", int'(stall_cycles), 0);
        tick();
        rst_n = 1'b1;
        #2;
        check_outs("after_reset", ALL_RUN);

        // Table of RUN-state vectors; stalls at 0 and 4, flushes at 0,4,6,7
        foreach (vecs[i]) begin
            tick();
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
                  vecs[i].wb, vecs[i].mr, vecs[i].br, 1'b0, 1'b0);
            #2;
            check_outs(vecs[i].name, vecs[i].exp);
        end
        tick();
        idle();
        #2;
        check_val("table_stall", int'(stall_cycles), 2);
        check_val("table_flush", int'(flush_cycles), 4);

        // Memory wait of 3 cycles, branch acted on in the release cycle
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 3'd0, 1'b1, 1'b1, 1'b0);
            #2;
            check_outs($sformatf("wait_%0d", i), FROZEN);
            tick();
        end
        drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 3'd0, 1'b1, 1'b1, 1'b1);
        #2;
        check_outs("wait_release_br", BR_FL);
        tick();
        idle();
        #2;
        check_outs("after_wait", ALL_RUN);
        check_val("wait_stall", int'(stall_cycles), 3);
        check_val("wait_flush", int'(flush_cycles), 1);
        check_val("wait_timeout", int'(mem_timeout), 0);

        // Timeout: four frozen cycles then ERR, sticky until reset
        do_reset();
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(5'd0, 5'd0, 0, 0, 5'd0, 0, 3'd0, 1'b0, 1'b1, 1'b0);
            #2;
            check_outs($sformatf("to_frozen_%0d", i), FROZEN);
            check_val($sformatf("to_flag_%0d", i), int'(mem_timeout), 0);
            tick();
        end
        #2;
        check_val("to_set", int'(mem_timeout), 1);
        check_outs("err_outs", FROZEN);
        mem_ready = 1'b1;
        tick();
        tick();
        #2;
        check_val("to_sticky", int'(mem_timeout), 1);
        check_outs("err_ready", FROZEN);
        check_val("err_stall_frozen", int'(stall_cycles), MAX_WAIT);
        rst_n = 1'b0;
        #1;
        check_val("rst_clr_timeout", int'(mem_timeout), 0);
        check_val("rst_clr_stall", int'(stall_cycles), 0);
        check_val("rst_clr_flush", int'(flush_cycles), 0);
        check_outs("rst_mid_err", FROZEN);
        tick();
        rst_n = 1'b1;

        // Saturation: 20 load-use hazards separated by ALU cycles
        for (int i = 0; i < 20; i++) begin
            drive(5'd3, 5'd0, 1, 0, 5'd3, 1, 3'b001, 1'b0, 1'b0, 1'b0);
            #2;
            check_outs($sformatf("sat_lu_%0d", i), LU_STL);
            tick();
            drive(5'd3, 5'd0, 1, 0, 5'd3, 1, 3'b000, 1'b0, 1'b0, 1'b0);
            tick();
        end
        #2;
        check_val("sat_stall", int'(stall_cycles), 15);
        check_val("sat_flush", int'(flush_cycles), 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
